// File: rtl/poly_rq_to_s3_stream.sv
// poly_rq_to_s3_stream: two-stage stream decoder from W-bit Rq coefficients to 2-bit ternary codes
module poly_rq_to_s3_stream #(
  parameter int N = 701,
  parameter int W = 13,
  parameter int IDXW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_data,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            len_err
);
  localparam int ND = (W + 2) / 2;
  localparam int UW = 2 * ND;
  localparam int PW = $clog2(3 * ND + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  logic s1_valid, s1_last, s2_ld, s1_ld, take, at_end, wrap;
  logic [PW-1:0] s1_p, p;
  logic [IDXW-1:0] s1_idx, cnt;
  logic [UW-1:0] u;
  logic [1:0] m;
  assign s2_ld = !out_valid || out_ready;
  assign s1_ld = !s1_valid || s2_ld;
  assign in_ready = s1_ld;
  assign take = in_valid && s1_ld;
  assign at_end = cnt == LAST_IDX;
  assign wrap = in_last || at_end;
  assign u = UW'($signed(in_data)) + UW'(3 << (W - 1));
  assign m = 2'(s1_p % PW'(3));
  // offset makes the value nonnegative; base-4 digits each weigh 1 mod 3, so their sum keeps the residue
  always_comb begin
    p = '0;
    for (int i = 0; i < ND; i++) p = p + PW'(u[2*i +: 2]);
  end
  // S1: accept a beat, register the folded residue with its index and framing flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p <= '0;
      s1_idx <= '0;
      s1_last <= 1'b0;
      cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (s1_ld) s1_valid <= in_valid;
      if (take) begin
        s1_p <= p;
        s1_idx <= cnt;
        s1_last <= wrap;
        cnt <= wrap ? '0 : cnt + IDXW'(1);
        len_err <= len_err || (in_last != at_end);
      end
    end
  // S2: final mod 3 and ternary encoding, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= 2'b00;
      out_idx <= '0;
      out_last <= 1'b0;
    end else if (s2_ld) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= m[1] ? 2'b11 : {1'b0, m[0]};
        out_idx <= s1_idx;
        out_last <= s1_last;
      end
    end
endmodule
